// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM states and flag indices
// for the ALU command sequencer.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_DIV = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_ROL = 4'hA;
  localparam logic [3:0] OP_ROR = 4'hB;
  localparam logic [3:0] OP_INC = 4'hC;
  localparam logic [3:0] OP_DEC = 4'hD;
  localparam logic [3:0] OP_LT  = 4'hE;
  localparam logic [3:0] OP_EQ  = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    MUL,
    RESP
  } state_t;

  // rsp_flags = {zero, carry, overflow}
  localparam int FLAG_W = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier, one
// partial product per cycle over WIDTH cycles.
// Ports: clk, rst (async high), i_start loads
// i_a/i_b; o_busy while iterating; o_done is high
// in the last cycle with o_product valid.
module alu_seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;

  logic [2*WIDTH-1:0] w_sum;
  logic               w_last;

  assign w_sum  = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_last = (r_cnt == CW'(WIDTH-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (w_last) begin
        r_cnt  <= '0;
        r_busy <= 1'b0;
      end else begin
        r_cnt  <= r_cnt + CW'(1);
      end
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_busy & w_last;
  // Final partial sum is forwarded so the product
  // is ready in the last iteration cycle.
  assign o_product = w_sum;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Initiator for an 8-bit combinational ALU: command in,
// registered ALU drive, captured result out. Multiply is
// done locally; divide-by-zero is trapped before issue.
// Ports: clk, rst (async high); cmd_valid/ready/op/a/b;
// alu_a/b/sel out, alu_out in; rsp_valid/ready/data/err.
// Optional: ALU_SEQ_FLAGS_EN adds rsp_flags {Z,C,V}.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [3:0]         cmd_op,
  input  logic [WIDTH-1:0]   cmd_a,
  input  logic [WIDTH-1:0]   cmd_b,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [3:0]         alu_sel,
  input  logic [WIDTH-1:0]   alu_out,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] rsp_data,
  output logic               rsp_err
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic [FLAG_W-1:0]  rsp_flags
`endif
);

  state_t             r_state;
  logic               r_cmd_ready;
  logic               r_rsp_valid;
  logic [2*WIDTH-1:0] r_rsp_data;
  logic               r_rsp_err;
  logic [WIDTH-1:0]   r_alu_a;
  logic [WIDTH-1:0]   r_alu_b;
  logic [3:0]         r_alu_sel;

  logic               w_accept;
  logic               w_div0;
  logic               w_is_mul;
  logic               w_mul_busy;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_mul_prod;

  assign w_accept = (r_state == IDLE) & cmd_valid
                  & r_cmd_ready;
  assign w_div0   = (cmd_op == OP_DIV)
                  & (cmd_b == '0);
  assign w_is_mul = (cmd_op == OP_MUL);

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_accept & w_is_mul),
    .i_a       (cmd_a),
    .i_b       (cmd_b),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_mul_prod)
  );

`ifdef ALU_SEQ_FLAGS_EN
  logic [3:0]        r_op;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [FLAG_W-1:0] r_flags;
  logic [WIDTH:0]    w_add;
  logic [WIDTH:0]    w_sub;
  logic [FLAG_W-1:0] w_iss_flags;
  logic [FLAG_W-1:0] w_mul_flags;

  assign w_add = {1'b0, r_a} + {1'b0, r_b};
  // Top bit of the extended difference is the borrow.
  assign w_sub = {1'b0, r_a} - {1'b0, r_b};

  always_comb begin
    w_iss_flags = '0;
    if (r_op == OP_ADD) begin
      w_iss_flags[FLAG_Z] = (alu_out == '0);
      w_iss_flags[FLAG_C] = w_add[WIDTH];
      w_iss_flags[FLAG_V] =
        (r_a[WIDTH-1] == r_b[WIDTH-1]) &
        (w_add[WIDTH-1] != r_a[WIDTH-1]);
    end else if (r_op == OP_SUB) begin
      w_iss_flags[FLAG_Z] = (alu_out == '0);
      w_iss_flags[FLAG_C] = w_sub[WIDTH];
      w_iss_flags[FLAG_V] =
        (r_a[WIDTH-1] != r_b[WIDTH-1]) &
        (w_sub[WIDTH-1] != r_a[WIDTH-1]);
    end
  end

  always_comb begin
    w_mul_flags         = '0;
    w_mul_flags[FLAG_Z] = (w_mul_prod == '0);
    w_mul_flags[FLAG_V] =
      (w_mul_prod[2*WIDTH-1:WIDTH] != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_flags <= '0;
    end else begin
      if (w_accept) begin
        r_op    <= cmd_op;
        r_a     <= cmd_a;
        r_b     <= cmd_b;
        r_flags <= '0;
      end else if (r_state == ISSUE) begin
        r_flags <= w_iss_flags;
      end else if (r_state == MUL && w_mul_done) begin
        r_flags <= w_mul_flags;
      end
    end
  end

  assign rsp_flags = r_flags;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_sel   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cmd_ready <= 1'b0;
            unique case (1'b1)
              w_div0: begin
                r_state     <= RESP;
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= '0;
                r_rsp_err   <= 1'b1;
              end
              w_is_mul: begin
                r_state <= MUL;
              end
              default: begin
                r_state   <= ISSUE;
                r_alu_a   <= cmd_a;
                r_alu_b   <= cmd_b;
                r_alu_sel <= cmd_op;
              end
            endcase
          end
        end
        ISSUE: begin
          r_state     <= RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= {{WIDTH{1'b0}}, alu_out};
          r_rsp_err   <= 1'b0;
        end
        MUL: begin
          if (w_mul_busy && w_mul_done) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_mul_prod;
            r_rsp_err   <= 1'b0;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_sel   = r_alu_sel;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a small
// behavioural ALU on the alu_* lines.
module tb_alu_cmd_sequencer;
  import alu_seq_pkg::*;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [3:0]     cmd_op = '0;
  logic [W-1:0]   cmd_a = '0;
  logic [W-1:0]   cmd_b = '0;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [3:0]     alu_sel;
  logic [W-1:0]   alu_out;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [2*W-1:0] rsp_data;
  logic           rsp_err;
`ifdef ALU_SEQ_FLAGS_EN
  logic [2:0]     rsp_flags;
`endif

  int errors = 0;
  int checks = 0;

  alu_cmd_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
`ifdef ALU_SEQ_FLAGS_EN
    ,
    .rsp_flags (rsp_flags)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural combinational ALU
  always_comb begin
    alu_out = '0;
    case (alu_sel)
      4'h0: alu_out = alu_a + alu_b;
      4'h1: alu_out = alu_a - alu_b;
      4'h3: alu_out = (alu_b != 0) ? alu_a / alu_b : '0;
      4'h4: alu_out = alu_a & alu_b;
      4'h5: alu_out = alu_a | alu_b;
      4'h6: alu_out = alu_a ^ alu_b;
      4'hE: alu_out = W'(alu_a < alu_b);
      4'hF: alu_out = W'(alu_a == alu_b);
      default: alu_out = '0;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Issue one command; lat counts cycles from the
  // accept edge to the first rsp_valid cycle.
  task automatic send(input logic [3:0] op,
                      input logic [W-1:0] a,
                      input logic [W-1:0] b,
                      output int lat);
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      step();
      lat++;
    end
    if (!rsp_valid) lat = 99;
  endtask

  task automatic finish_rsp(input string tag);
    rsp_ready = 1'b1;
    step();
    chk({tag, "_hs_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_hs_ready"}, 32'(cmd_ready), 1);
  endtask

  initial begin
    int lat;
    int stale;

    // Reset state
    step();
    step();
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data",  32'(rsp_data),  0);
    chk("rst_rsp_err",   32'(rsp_err),   0);
    chk("rst_alu_a",     32'(alu_a),     0);
    chk("rst_alu_b",     32'(alu_b),     0);
    chk("rst_alu_sel",   32'(alu_sel),   0);
    rst = 1'b0;
    step();

    // Reset in the middle of a multiply
    cmd_op    = OP_MUL;
    cmd_a     = 8'hFF;
    cmd_b     = 8'hFF;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("mulrst_busy_ready", 32'(cmd_ready), 0);
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    chk("mulrst_valid", 32'(rsp_valid), 0);
    chk("mulrst_ready", 32'(cmd_ready), 1);
    step();
    rst = 1'b0;
    step();
    chk("mulrst_post_ready", 32'(cmd_ready), 1);
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (rsp_valid) stale++;
    end
    chk("mulrst_no_stale", 32'(stale), 0);

    // ADD wraps to 8 bits
    rsp_ready = 1'b1;
    cmd_op    = OP_ADD;
    cmd_a     = 8'd200;
    cmd_b     = 8'd100;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("add_issue_sel", 32'(alu_sel), 0);
    chk("add_issue_a",   32'(alu_a), 200);
    chk("add_issue_b",   32'(alu_b), 100);
    chk("add_issue_vld", 32'(rsp_valid), 0);
    step();
    chk("add_valid", 32'(rsp_valid), 1);
    chk("add_data",  32'(rsp_data), 44);
    chk("add_err",   32'(rsp_err), 0);
    finish_rsp("add");

    // Multiply
    send(OP_MUL, 8'd25, 8'd12, lat);
    chk("mul1_lat",  32'(lat), 9);
    chk("mul1_data", 32'(rsp_data), 300);
    chk("mul1_err",  32'(rsp_err), 0);
    chk("mul1_hold_sel", 32'(alu_sel), 0);
    chk("mul1_hold_a",   32'(alu_a), 200);
    finish_rsp("mul1");
    send(OP_MUL, 8'hFF, 8'hFF, lat);
    chk("mul2_lat",  32'(lat), 9);
    chk("mul2_data", 32'(rsp_data), 32'hFE01);
    finish_rsp("mul2");

    // Divide by zero trap, then a real divide
    send(OP_DIV, 8'd9, 8'd0, lat);
    chk("div0_lat",  32'(lat), 1);
    chk("div0_err",  32'(rsp_err), 1);
    chk("div0_data", 32'(rsp_data), 0);
    chk("div0_sel",  32'(alu_sel), 0);
    finish_rsp("div0");
    send(OP_DIV, 8'd9, 8'd2, lat);
    chk("div_lat",  32'(lat), 2);
    chk("div_data", 32'(rsp_data), 4);
    chk("div_err",  32'(rsp_err), 0);
    chk("div_sel",  32'(alu_sel), 3);
    finish_rsp("div");

    // Backpressure with a pending new command
    rsp_ready = 1'b0;
    send(OP_EQ, 8'h5A, 8'h5A, lat);
    chk("bp_lat", 32'(lat), 2);
    cmd_op    = OP_ADD;
    cmd_a     = 8'd1;
    cmd_b     = 8'd1;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_data",  32'(rsp_data), 1);
      chk("bp_ready", 32'(cmd_ready), 0);
      chk("bp_alu_a", 32'(alu_a), 32'h5A);
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_hs_valid", 32'(rsp_valid), 0);
    chk("bp_hs_ready", 32'(cmd_ready), 1);
    step();
    cmd_valid = 1'b0;
    chk("bp_next_a", 32'(alu_a), 1);
    step();
    chk("bp_next_data", 32'(rsp_data), 2);
    finish_rsp("bp_next");

`ifdef ALU_SEQ_FLAGS_EN
    send(OP_ADD, 8'h80, 8'h80, lat);
    chk("flg_add_data",  32'(rsp_data), 0);
    chk("flg_add_flags", 32'(rsp_flags), 3'b111);
    finish_rsp("flg_add");
    send(OP_MUL, 8'd2, 8'd3, lat);
    chk("flg_mul_data",  32'(rsp_data), 6);
    chk("flg_mul_flags", 32'(rsp_flags), 3'b000);
    finish_rsp("flg_mul");
`endif

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Initiator side of the 8-bit combinational ALU interface (A, B, 4-bit select, 8-bit result). Accepts operation commands over a valid/ready handshake, drives the ALU operand and select lines from registers, and captures the ALU result. Returns responses over a second valid/ready handshake. Natively performs multiply (opcode 4'b0010, unsupported by the ALU) with a multi-cycle shift-add unit, and traps divide-by-zero before issue.

Parameters:
- WIDTH, 8, operand width; ALU result width = WIDTH, response width = 2*WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  4  opcode, same encoding as ALU select; 4'b0010 = multiply.
- cmd_a  input  WIDTH  operand A.
- cmd_b  input  WIDTH  operand B.
- alu_a  output  WIDTH  to ALU A, registered.
- alu_b  output  WIDTH  to ALU B, registered.
- alu_sel  output  4  to ALU select, registered.
- alu_out  input  WIDTH  from ALU result (combinational path).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_data  output  2*WIDTH  result; zero-extended ALU result, or full product for multiply.
- rsp_err  output  1  1 = divide-by-zero trap.

Behaviour:
- Reset (async, while rst=1):
  - state=IDLE; cmd_ready=1; rsp_valid=0; rsp_data=0; rsp_err=0.
  - alu_a=0, alu_b=0, alu_sel=0; multiply counter=0.
- Reset mid-operation abandons the command with no response; the first post-reset cycle is IDLE.
- FSM states: IDLE, ISSUE, MUL, RESP.
- IDLE:
  - cmd_ready=1.
  - A command is accepted when cmd_valid & cmd_ready; op, a and b are latched that edge.
  - op==4'b0011 and b==0 -> RESP with rsp_data=0, rsp_err=1; the ALU is not driven.
  - op==4'b0010 -> MUL.
  - Any other op -> ISSUE, with alu_a/alu_b/alu_sel loaded from the command that edge.
- ISSUE:
  - Exactly one cycle; ALU inputs are stable.
  - At the end of the cycle, alu_out is sampled into rsp_data[WIDTH-1:0], upper bits are 0, rsp_err=0 -> RESP.
- MUL:
  - Shift-add over exactly WIDTH cycles, using a counter 0..WIDTH-1.
  - Product is unsigned 2*WIDTH bits with no truncation.
  - When count reaches WIDTH-1 -> RESP with rsp_data=product. ALU outputs hold their previous values.
- RESP:
  - rsp_valid=1; rsp_data/rsp_err are held stable until rsp_valid & rsp_ready.
  - On handshake -> IDLE.
- cmd_ready=0 in every state except IDLE; a command is never accepted in the same cycle as a response handshake.
- Latency, accept edge to first rsp_valid cycle: ALU op = 2 cycles; multiply = WIDTH+1 cycles; div-by-zero = 1 cycle.
- ALU outputs hold their last issued values between commands (no glitching to 0).
- Opcodes 4'b1110/4'b1111 return 0 or 1 in rsp_data[0], as produced by the ALU.

Optional Feature:
- ALU_SEQ_FLAGS_EN defined:
  - Adds output rsp_flags[2:0], valid with rsp_valid: {zero, carry, overflow}.
  - zero = (rsp_data==0).
  - carry = unsigned carry-out for add / borrow for sub, computed from the latched operands.
  - overflow = signed overflow for add/sub, or product[2*WIDTH-1:WIDTH]!=0 for multiply.
  - All flags are 0 for other ops and for the div-by-zero trap; reset value 0.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode localparams: OP_ADD..OP_EQ, including OP_MUL=4'b0010 and OP_DIV=4'b0011;
  - state enum typedef (IDLE/ISSUE/MUL/RESP);
  - flag bit index constants.
- One sub-module, alu_seq_mul: iterative unsigned shift-add multiplier with start/busy/done ports and WIDTH parameter, instantiated by the sequencer for MUL.

Test Plan:
- Reset: assert rst mid-MUL (op=2, a=8'hFF, b=8'hFF, after 3 cycles) -> rsp_valid=0 immediately; cmd_ready=1 after release; no stale response.
- ADD: op=0, a=8'd200, b=8'd100, rsp_ready=1 -> alu_sel=0, alu_a=200, alu_b=100 in ISSUE; rsp_data=16'd44, rsp_err=0, rsp_valid two cycles after accept.
- MUL: op=2, a=8'd25, b=8'd12 -> rsp_data=16'd300 after WIDTH+1=9 cycles; a=b=8'hFF -> 16'hFE01.
- Div-by-zero: op=3, a=8'd9, b=0 -> rsp_err=1, rsp_data=0 one cycle after accept, alu_sel unchanged; then op=3, a=9, b=2 -> rsp_data=4, rsp_err=0.
- Backpressure: op=4'b1111, a=b=8'h5A, rsp_ready=0 for 5 cycles -> rsp_valid held, rsp_data=1 stable, cmd_ready=0 throughout; a new cmd_valid is ignored until after the handshake.
- ALU_SEQ_FLAGS_EN: op=0, a=8'h80, b=8'h80 -> rsp_data=0, rsp_flags=3'b111; op=2, a=8'd2, b=8'd3 -> rsp_flags=3'b000.
